// File: rtl/img2col_window_feeder.sv
// Write-side producer for the img2col window buffer: streams pixels into a column-major
// K*K window, reloading all of it at the start of each window-row and only the newest column otherwise.
module img2col_window_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int K          = 5,
  parameter int ROW_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_start,
  input  logic [5:0]            cfg_cols,
  input  logic [ROW_W-1:0]      cfg_rows,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  pu_start,
  output logic                  g_wr_en,
  output logic [ADDR_WIDTH-1:0] g_wr_addr,
  output logic [DATA_WIDTH-1:0] g_wr_data,
  input  logic                  g_rd_strobe,
  output logic [5:0]            round,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  // Pixel handshake: a pixel transfers on a rising clk edge where pix_valid and pix_ready
  // are both high; pix_ready depends only on state, never on pix_valid.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(K * K - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_ADDR  = ADDR_WIDTH'(K * (K - 1));

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [5:0]              cols_q;
  logic [ROW_W-1:0]        rows_q;
  logic [ROW_W-1:0]        row_q;
  logic [5:0]              round_q;
  logic                    busy_q;
  logic                    pu_start_q;
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;

  logic start_acc;
  logic accept;
  logic win_done;
  logic last_col;
  logic last_row;

  assign start_acc = (state_q == S_IDLE) && job_start;
  assign accept    = (state_q == S_FILL) && pix_valid;
  // The window is released once the PU strobe has risen and then fallen again.
  assign win_done  = (state_q == S_WAIT_LO) && !g_rd_strobe;
  assign last_col  = (round_q == cols_q - 6'd1);
  assign last_row  = (row_q == rows_q - 1'b1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (job_start) state_d = S_FILL;
      S_FILL:    if (accept && addr_q == LAST_ADDR) state_d = S_WAIT_HI;
      S_WAIT_HI: if (g_rd_strobe) state_d = S_WAIT_LO;
      S_WAIT_LO: if (!g_rd_strobe) state_d = (last_col && last_row) ? S_DONE : S_FILL;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
      row_q      <= '0;
      round_q    <= '0;
      busy_q     <= 1'b0;
      pu_start_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pu_start_q <= start_acc;
      wr_en_q    <= accept;
      if (accept) begin
        wr_addr_q <= addr_q;
        wr_data_q <= pix_data;
        if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
      end
      if (start_acc) begin
        cols_q  <= (cfg_cols == 6'd0) ? 6'd1 : cfg_cols;
        rows_q  <= (cfg_rows == '0) ? ROW_W'(1) : cfg_rows;
        row_q   <= '0;
        round_q <= '0;
        addr_q  <= '0;
        busy_q  <= 1'b1;
      end
      // round only moves here, so the PU sees a stable index for the whole read.
      if (win_done) begin
        if (last_col) begin
          round_q <= '0;
          row_q   <= row_q + 1'b1;
          addr_q  <= '0;
        end else begin
          round_q <= round_q + 6'd1;
          addr_q  <= COL_ADDR;
        end
      end
      if (state_q == S_DONE) busy_q <= 1'b0;
    end
  end

  assign pix_ready = (state_q == S_FILL);
  assign pu_start  = pu_start_q;
  assign g_wr_en   = wr_en_q;
  assign g_wr_addr = wr_addr_q;
  assign g_wr_data = wr_data_q;
  assign round     = round_q;
  assign busy      = busy_q;
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule
